// File: rtl/hmmm_pkg.sv
// Shared types and widths for the HMMM board SRAM boot path.
package hmmm_pkg;

  typedef enum logic [1:0] {
    LOAD_HI = 2'd0,
    LOAD_LO = 2'd1,
    WRITE   = 2'd2,
    RUN     = 2'd3
  } boot_state_t;

  localparam int SRAM_ADDR_WIDTH = 8;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int HOLD_WIDTH      = 4;

endpackage

// File: rtl/flopenr_2ph.sv
// Two-phase master/slave register with enable and synchronous reset.
// The master captures on ph2; the slave copies the master on ph1.
module flopenr_2ph #(
  parameter int WIDTH = 8
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] master;

  always_ff @(posedge ph2) begin
    if (reset)   master <= '0;
    else if (en) master <= d;
  end

  always_ff @(posedge ph1) begin
    q <= master;
  end

endmodule

// File: rtl/sram_boot_arbiter.sv
// Owns the external SRAM port: loads a byte-serial image into SRAM while
// the processor is held in reset, then hands the SRAM over to the processor.
module sram_boot_arbiter
  import hmmm_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int RESET_HOLD = 2
) (
  input  logic                  ph1,
  input  logic                  ph2,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  input  logic                  reload,
  input  logic                  cpu_memwrite,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  input  logic [7:0]            cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] sram_adr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_drive,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  boot_done,
  output logic                  load_err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_DONE = HOLD_WIDTH'(RESET_HOLD);

  boot_state_t           state, state_n;
  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [7:0]            hi_byte, lo_byte, lo_d;
  logic                  hi_en, lo_en;
  logic                  end_flag, end_n;
  logic                  err, err_n;
  logic [HOLD_WIDTH-1:0] hold, hold_n;

  assign state = boot_state_t'(state_q);

  flopenr_2ph #(.WIDTH(2)) state_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(state_n), .q(state_q));
  flopenr_2ph #(.WIDTH(ADDR_WIDTH)) addr_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(addr_n), .q(addr));
  flopenr_2ph #(.WIDTH(8)) hi_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(hi_en), .d(ld_byte), .q(hi_byte));
  flopenr_2ph #(.WIDTH(8)) lo_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(lo_en), .d(lo_d), .q(lo_byte));
  flopenr_2ph #(.WIDTH(1)) end_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(end_n), .q(end_flag));
  flopenr_2ph #(.WIDTH(1)) err_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(err_n), .q(err));
  flopenr_2ph #(.WIDTH(HOLD_WIDTH)) hold_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(hold_n), .q(hold));

  // An odd-length image pads the last word with a zero low byte and flags it;
  // running off the top of SRAM also flags and stops rather than wrapping.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    end_n   = end_flag;
    err_n   = err;
    hold_n  = '0;
    hi_en   = 1'b0;
    lo_en   = 1'b0;
    lo_d    = ld_byte;
    case (state)
      LOAD_HI: begin
        if (ld_valid) begin
          hi_en = 1'b1;
          end_n = ld_last;
          if (ld_last) begin
            lo_en   = 1'b1;
            lo_d    = 8'h00;
            err_n   = 1'b1;
            state_n = WRITE;
          end else begin
            state_n = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        if (ld_valid) begin
          lo_en   = 1'b1;
          end_n   = ld_last;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (addr != ADDR_MAX) addr_n = addr + ADDR_WIDTH'(1);
        if (end_flag || addr == ADDR_MAX) begin
          state_n = RUN;
          if (!end_flag) err_n = 1'b1;
        end else begin
          state_n = LOAD_HI;
        end
      end
      RUN: begin
        hold_n = (hold == HOLD_DONE) ? hold : hold + HOLD_WIDTH'(1);
        if (reload) begin
          state_n = LOAD_HI;
          addr_n  = '0;
          hold_n  = '0;
        end
      end
      default: state_n = LOAD_HI;
    endcase
  end

  always_comb begin
    ld_ready   = 1'b0;
    sram_adr   = '0;
    sram_wdata = '0;
    sram_drive = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    cpu_rdata  = '0;
    case (state)
      LOAD_HI, LOAD_LO: ld_ready = 1'b1;
      WRITE: begin
        sram_adr   = addr;
        sram_wdata = DATA_WIDTH'({hi_byte, lo_byte});
        sram_drive = 1'b1;
        sram_we_n  = 1'b0;
      end
      RUN: begin
        sram_adr   = cpu_adr;
        sram_wdata = DATA_WIDTH'(cpu_wdata);
        sram_drive = cpu_memwrite;
        sram_we_n  = ~cpu_memwrite;
        sram_oe_n  = cpu_memwrite;
        cpu_rdata  = sram_rdata;
      end
      default: ;
    endcase
  end

  assign sram_ce_n = 1'b0;
  assign boot_done = (state == RUN);
  assign cpu_reset = (state != RUN) || (hold != HOLD_DONE);
  assign load_err  = err;

endmodule
